// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_pkg
// Description : Shared state codes, SDRAM command codes and default bus widths
//               for the SDRAM controller arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_pkg;

  // Default pin-bus widths
  localparam int DEF_CMD_W  = 5;
  localparam int DEF_ADDR_W = 12;

  // Arbiter state encoding (also exported on arb_state for debug)
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_INIT  = 3'd0;
  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd1;
  localparam logic [STATE_W-1:0] ST_AREF  = 3'd2;
  localparam logic [STATE_W-1:0] ST_WRITE = 3'd3;
  localparam logic [STATE_W-1:0] ST_READ  = 3'd4;

  // SDRAM command word {CKE,CS,RAS,CAS,WE}
  localparam logic [4:0] C_CMD_NOP = 5'b10111;

endpackage : sdram_pkg
`default_nettype wire

// File: rtl/sdram_cmd_mux.sv
`default_nettype none
// ============================================================================
// Module      : sdram_cmd_mux
// Description : Selects the granted engine's command/address onto the SDRAM
//               pins and drives the DQ output-enable from the arbiter state.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_cmd_mux
  import sdram_pkg::*;
#(
  parameter int CMD_W  = DEF_CMD_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [STATE_W-1:0] state,
  input  logic [CMD_W-1:0]   init_cmd,
  input  logic [ADDR_W-1:0]  init_addr,
  input  logic [CMD_W-1:0]   aref_cmd,
  input  logic [ADDR_W-1:0]  aref_addr,
  input  logic [CMD_W-1:0]   wr_cmd,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [CMD_W-1:0]   rd_cmd,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [CMD_W-1:0]   sdram_cmd,
  output logic [ADDR_W-1:0]  sdram_addr,
  output logic               dq_oe
);

  // Pin bus follows the owner of the current state; unknown codes behave as INIT
  always_comb begin
    sdram_cmd  = init_cmd;
    sdram_addr = init_addr;
    dq_oe      = 1'b0;
    case (state)
      ST_IDLE: begin
        sdram_cmd  = CMD_W'(C_CMD_NOP);
        sdram_addr = '0;
      end
      ST_AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
      end
      ST_WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        dq_oe      = 1'b1;
      end
      ST_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
      end
      default: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
    endcase
  end

endmodule : sdram_cmd_mux
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter
// Description : Central SDRAM scheduler. Sequences init, then grants the bus
//               to refresh / write / read engines with refresh priority at
//               burst boundaries, round-robin between write and read, and a
//               sticky refresh-starvation watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int CMD_W         = DEF_CMD_W,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int AREF_WAIT_MAX = 16
) (
  input  logic                S_CLK,
  input  logic                RST_N,
  input  logic                flag_init,
  input  logic [CMD_W-1:0]    init_cmd,
  input  logic [ADDR_W-1:0]   init_addr,
  input  logic                aref_req,
  input  logic                aref_ack,
  input  logic [CMD_W-1:0]    aref_cmd,
  input  logic [ADDR_W-1:0]   aref_addr,
  input  logic                wr_req,
  input  logic                wr_ack,
  input  logic [CMD_W-1:0]    wr_cmd,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                rd_req,
  input  logic                rd_ack,
  input  logic [CMD_W-1:0]    rd_cmd,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                aref_en,
  output logic                wr_en,
  output logic                rd_en,
  output logic [CMD_W-1:0]    sdram_cmd,
  output logic [ADDR_W-1:0]   sdram_addr,
  output logic                dq_oe,
  output logic [STATE_W-1:0]  arb_state,
  output logic                aref_late
);

  localparam int WCNT_W = $clog2(AREF_WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] C_WAIT_MAX = WCNT_W'(AREF_WAIT_MAX);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  logic [STATE_W-1:0] r_last_grant;
  logic [WCNT_W-1:0]  r_wait_cnt;
  logic               r_aref_late;

  // State register and round-robin memory of the last data grant
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ST_INIT;
      r_last_grant <= ST_READ;
    end else begin
      r_state <= w_next_state;
      if (w_next_state == ST_WRITE || w_next_state == ST_READ) begin
        r_last_grant <= w_next_state;
      end
    end
  end

  // Next-state: refresh wins at burst boundaries, write/read alternate
  always_comb begin
    w_next_state = ST_INIT;
    case (r_state)
      ST_INIT:  w_next_state = flag_init ? ST_IDLE : ST_INIT;
      ST_IDLE: begin
        if (aref_req)                 w_next_state = ST_AREF;
        else if (wr_req && rd_req)    w_next_state = (r_last_grant == ST_READ) ? ST_WRITE : ST_READ;
        else if (wr_req)              w_next_state = ST_WRITE;
        else if (rd_req)              w_next_state = ST_READ;
        else                          w_next_state = ST_IDLE;
      end
      ST_AREF:  w_next_state = aref_ack ? ST_IDLE : ST_AREF;
      ST_WRITE: w_next_state = wr_ack ? (aref_req ? ST_AREF : ST_IDLE) : ST_WRITE;
      ST_READ:  w_next_state = rd_ack ? (aref_req ? ST_AREF : ST_IDLE) : ST_READ;
      default:  w_next_state = ST_INIT;
    endcase
  end

  // Engine enables decoded from the registered state
  always_comb begin
    aref_en   = (r_state == ST_AREF);
    wr_en     = (r_state == ST_WRITE);
    rd_en     = (r_state == ST_READ);
    arb_state = r_state;
    aref_late = r_aref_late;
  end

  // Watchdog: count cycles refresh is pending but not granted; flag is sticky
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wait_cnt  <= '0;
      r_aref_late <= 1'b0;
    end else begin
      if (!aref_req || r_state == ST_AREF) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != C_WAIT_MAX) begin
        r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
      end
      if (r_wait_cnt == C_WAIT_MAX) begin
        r_aref_late <= 1'b1;
      end
    end
  end

  sdram_cmd_mux #(
    .CMD_W  (CMD_W),
    .ADDR_W (ADDR_W)
  ) u_cmd_mux (
    .state      (r_state),
    .init_cmd   (init_cmd),
    .init_addr  (init_addr),
    .aref_cmd   (aref_cmd),
    .aref_addr  (aref_addr),
    .wr_cmd     (wr_cmd),
    .wr_addr    (wr_addr),
    .rd_cmd     (rd_cmd),
    .rd_addr    (rd_addr),
    .sdram_cmd  (sdram_cmd),
    .sdram_addr (sdram_addr),
    .dq_oe      (dq_oe)
  );

endmodule : sdram_arbiter
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_arbiter
// Description : Self-checking bench for sdram_arbiter: directed vector table
//               plus hand-written init, round-robin, starvation and
//               async-reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

  localparam logic [4:0]  C_INIT_CMD  = 5'h01;
  localparam logic [11:0] C_INIT_ADDR = 12'h111;
  localparam logic [4:0]  C_AREF_CMD  = 5'h02;
  localparam logic [11:0] C_AREF_ADDR = 12'h222;
  localparam logic [4:0]  C_WR_CMD    = 5'h03;
  localparam logic [11:0] C_WR_ADDR   = 12'h333;
  localparam logic [4:0]  C_RD_CMD    = 5'h04;
  localparam logic [11:0] C_RD_ADDR   = 12'h444;
  localparam logic [4:0]  C_NOP       = 5'b10111;

  logic        S_CLK = 1'b0;
  logic        RST_N;
  logic        flag_init;
  logic        aref_req, aref_ack, wr_req, wr_ack, rd_req, rd_ack;
  logic [4:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [11:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic        aref_en, wr_en, rd_en, dq_oe, aref_late;
  logic [4:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [2:0]  arb_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 S_CLK = ~S_CLK;

  sdram_arbiter #(.CMD_W(5), .ADDR_W(12), .AREF_WAIT_MAX(16)) dut (
    .S_CLK(S_CLK), .RST_N(RST_N), .flag_init(flag_init),
    .init_cmd(init_cmd), .init_addr(init_addr),
    .aref_req(aref_req), .aref_ack(aref_ack), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_cmd(wr_cmd), .wr_addr(wr_addr),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_cmd(rd_cmd), .rd_addr(rd_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .dq_oe(dq_oe),
    .arb_state(arb_state), .aref_late(aref_late)
  );

  typedef struct {
    logic       aref_req;
    logic       wr_req;
    logic       rd_req;
    logic       aref_ack;
    logic       wr_ack;
    logic       rd_ack;
    logic [2:0] exp_state;
  } vec_t;

  vec_t tbl [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare every output against what the given state must produce
  task automatic check_outputs(input string tag, input logic [2:0] st, input logic late);
    logic [4:0]  ecmd;
    logic [11:0] eaddr;
    case (st)
      3'd1:    begin ecmd = C_NOP;      eaddr = 12'h000;     end
      3'd2:    begin ecmd = C_AREF_CMD; eaddr = C_AREF_ADDR; end
      3'd3:    begin ecmd = C_WR_CMD;   eaddr = C_WR_ADDR;   end
      3'd4:    begin ecmd = C_RD_CMD;   eaddr = C_RD_ADDR;   end
      default: begin ecmd = C_INIT_CMD; eaddr = C_INIT_ADDR; end
    endcase
    check({tag, ".state"},   32'(arb_state), 32'(st));
    check({tag, ".aref_en"}, 32'(aref_en),   32'(st == 3'd2));
    check({tag, ".wr_en"},   32'(wr_en),     32'(st == 3'd3));
    check({tag, ".rd_en"},   32'(rd_en),     32'(st == 3'd4));
    check({tag, ".dq_oe"},   32'(dq_oe),     32'(st == 3'd3));
    check({tag, ".cmd"},     32'(sdram_cmd), 32'(ecmd));
    check({tag, ".addr"},    32'(sdram_addr), 32'(eaddr));
    check({tag, ".late"},    32'(aref_late), 32'(late));
  endtask

  task automatic step();
    @(posedge S_CLK);
    #1;
  endtask

  task automatic clear_inputs();
    aref_req = 0; wr_req = 0; rd_req = 0;
    aref_ack = 0; wr_ack = 0; rd_ack = 0;
  endtask

  initial begin
    logic [2:0] rr_order [4];

    //            aref wr rd aack wack rack  exp
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 3'd1};  // idle stays idle
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 3'd3};  // single write
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 3'd3};  // req drop does not end burst
    tbl[3]  = '{0, 0, 0, 0, 0, 1, 3'd3};  // foreign ack ignored
    tbl[4]  = '{0, 0, 0, 0, 1, 0, 3'd1};  // wr_ack -> idle
    tbl[5]  = '{0, 1, 1, 0, 0, 0, 3'd4};  // both, last=WRITE -> READ
    tbl[6]  = '{0, 1, 1, 0, 0, 1, 3'd1};
    tbl[7]  = '{0, 1, 1, 0, 0, 0, 3'd3};  // both, last=READ -> WRITE
    tbl[8]  = '{0, 1, 1, 0, 1, 0, 3'd1};
    tbl[9]  = '{0, 1, 1, 0, 0, 0, 3'd4};
    tbl[10] = '{1, 0, 1, 0, 0, 1, 3'd2};  // ack + aref_req -> AREF directly
    tbl[11] = '{1, 1, 0, 0, 0, 0, 3'd2};  // AREF waits for ack
    tbl[12] = '{0, 1, 0, 1, 0, 0, 3'd1};
    tbl[13] = '{1, 1, 1, 0, 0, 0, 3'd2};  // aref wins in idle
    tbl[14] = '{0, 1, 0, 1, 0, 0, 3'd1};
    tbl[15] = '{0, 1, 0, 0, 0, 0, 3'd3};
    tbl[16] = '{1, 1, 0, 0, 0, 0, 3'd3};  // refresh rises mid-write
    tbl[17] = '{1, 0, 0, 0, 1, 0, 3'd2};  // wr_ack -> AREF, no idle
    tbl[18] = '{0, 0, 0, 1, 0, 0, 3'd1};
    tbl[19] = '{0, 0, 0, 1, 0, 0, 3'd1};  // stray aref_ack in idle
    tbl[20] = '{0, 0, 1, 0, 0, 0, 3'd4};  // single read
    tbl[21] = '{0, 0, 0, 0, 1, 0, 3'd4};  // wr_ack ignored in read
    tbl[22] = '{0, 0, 0, 0, 0, 1, 3'd1};

    init_cmd = C_INIT_CMD; init_addr = C_INIT_ADDR;
    aref_cmd = C_AREF_CMD; aref_addr = C_AREF_ADDR;
    wr_cmd   = C_WR_CMD;   wr_addr   = C_WR_ADDR;
    rd_cmd   = C_RD_CMD;   rd_addr   = C_RD_ADDR;
    clear_inputs();
    flag_init = 0;
    RST_N     = 0;

    // Reset state
    step(); step();
    check_outputs("reset", 3'd0, 1'b0);
    RST_N = 1;

    // Init: hold INIT for 19 cycles, flag_init at cycle 20 -> IDLE
    for (int i = 1; i < 20; i++) begin
      step();
      check("init.hold_state", 32'(arb_state), 32'd0);
      check("init.hold_cmd",   32'(sdram_cmd), 32'(C_INIT_CMD));
    end
    flag_init = 1;
    step();
    check_outputs("init.done", 3'd1, 1'b0);

    // Directed vector table
    for (int i = 0; i < 23; i++) begin
      aref_req = tbl[i].aref_req; wr_req = tbl[i].wr_req; rd_req = tbl[i].rd_req;
      aref_ack = tbl[i].aref_ack; wr_ack = tbl[i].wr_ack; rd_ack = tbl[i].rd_ack;
      step();
      check_outputs($sformatf("vec%0d", i), tbl[i].exp_state, 1'b0);
    end
    clear_inputs();

    // Round-robin with both requesters held, ack after 8 cycles per burst
    rr_order[0] = 3'd3; rr_order[1] = 3'd4; rr_order[2] = 3'd3; rr_order[3] = 3'd4;
    wr_req = 1; rd_req = 1;
    for (int b = 0; b < 4; b++) begin
      step();
      check_outputs($sformatf("rr%0d.grant", b), rr_order[b], 1'b0);
      for (int c = 1; c < 8; c++) begin
        step();
        check($sformatf("rr%0d.hold", b), 32'(arb_state), 32'(rr_order[b]));
      end
      if (rr_order[b] == 3'd3) wr_ack = 1; else rd_ack = 1;
      step();
      wr_ack = 0; rd_ack = 0;
      check_outputs($sformatf("rr%0d.nop", b), 3'd1, 1'b0);
    end
    clear_inputs();

    // Starvation: refresh pending during a write with no ack for 20 cycles
    wr_req = 1;
    step();
    check("starve.write", 32'(arb_state), 32'd3);
    wr_req = 0; aref_req = 1;
    for (int c = 0; c < 14; c++) step();
    check("starve.late_early", 32'(aref_late), 32'd0);
    for (int c = 0; c < 6; c++) step();
    check("starve.late_set", 32'(aref_late), 32'd1);
    check("starve.still_write", 32'(arb_state), 32'd3);
    wr_ack = 1;
    step();
    wr_ack = 0;
    check_outputs("starve.aref", 3'd2, 1'b1);
    aref_ack = 1; aref_req = 0;
    step();
    aref_ack = 0;
    check_outputs("starve.after", 3'd1, 1'b1);
    for (int c = 0; c < 3; c++) step();
    check("starve.sticky", 32'(aref_late), 32'd1);

    // Asynchronous reset in the middle of a read burst
    rd_req = 1;
    step();
    check("rst.read", 32'(rd_en), 32'd1);
    #2;
    RST_N = 0;
    #1;
    check_outputs("rst.async", 3'd0, 1'b0);
    clear_inputs();
    step();
    check_outputs("rst.held", 3'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sdram_arbiter
`default_nettype wire
